// File: rtl/axis_to_vector_tdest.sv
// Reassembles tdest-filtered AXI-stream frames into a held parallel vector; malformed frames are
// dropped and flagged. Define AXIS_TO_VECTOR_ERR_COUNT_EN to add the saturating err_count output.
module axis_to_vector_tdest #(
    parameter int unsigned VEC_BYTES  = 2,
    parameter int unsigned AXIS_BYTES = 1,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned TDEST      = 0,
    parameter int unsigned DEST_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    sreset,
    input  logic [AXIS_BYTES*8-1:0] axis_tdata,
    input  logic                    axis_tvalid,
    output logic                    axis_tready,
    input  logic                    axis_tlast,
    input  logic [AXIS_BYTES-1:0]   axis_tkeep,
    input  logic [DEST_WIDTH-1:0]   axis_tdest,
    output logic [VEC_BYTES*8-1:0]  vec,
    output logic                    vec_valid,
    output logic                    err_short,
    output logic                    err_long
`ifdef AXIS_TO_VECTOR_ERR_COUNT_EN
    ,
    output logic [15:0]             err_count
`endif
);

    localparam int unsigned BEAT_W  = AXIS_BYTES * 8;
    localparam int unsigned VEC_W   = VEC_BYTES * 8;
    localparam int unsigned CTR_MAX = VEC_BYTES / AXIS_BYTES - 1;
    localparam int unsigned CTR_W   = (CTR_MAX > 0) ? $clog2(CTR_MAX + 1) : 1;
    localparam logic [CTR_W-1:0] CTR_INIT = MSB_FIRST ? CTR_W'(CTR_MAX) : '0;
    localparam logic [CTR_W-1:0] CTR_LAST = MSB_FIRST ? '0 : CTR_W'(CTR_MAX);

    if (AXIS_BYTES == 0 || VEC_BYTES == 0 || (VEC_BYTES % AXIS_BYTES) != 0) begin : gen_bad_cfg
        $error("VEC_BYTES must be a nonzero multiple of AXIS_BYTES");
    end

    typedef enum logic [0:0] {StCollect, StDiscard} state_e;

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [VEC_W-1:0]   cap_q, cap_d, cap_merged;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               vec_valid_q, vec_valid_d;
    logic               err_short_q, err_short_d;
    logic               err_long_q, err_long_d;
    logic               accept;
    logic               at_last;
    logic               unused_tkeep;

    // tkeep carries no information here: every byte of a beat is treated as valid.
    assign unused_tkeep = ^axis_tkeep;

    assign axis_tready = !sreset;
    assign accept      = axis_tvalid & axis_tready & (axis_tdest == DEST_WIDTH'(TDEST));
    assign at_last     = (ctr_q == CTR_LAST);

    always_comb begin
        cap_merged = cap_q;
        cap_merged[int'(ctr_q) * BEAT_W +: BEAT_W] = axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q     <= StCollect;
            ctr_q       <= CTR_INIT;
            cap_q       <= '0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            cap_q       <= cap_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        if (accept) begin
            unique case (state_q)
                StCollect: begin
                    if (!at_last && !axis_tlast) begin
                        ctr_d = MSB_FIRST ? ctr_q - CTR_W'(1) : ctr_q + CTR_W'(1);
                    end else begin
                        ctr_d = CTR_INIT;
                        if (at_last && !axis_tlast) begin
                            state_d = StDiscard;
                        end
                    end
                end
                StDiscard: begin
                    if (axis_tlast) begin
                        state_d = StCollect;
                    end
                end
                default: state_d = StCollect;
            endcase
        end
    end

    always_comb begin
        cap_d       = cap_q;
        vec_d       = vec_q;
        vec_valid_d = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        if (accept && state_q == StCollect) begin
            if (!at_last && !axis_tlast) begin
                cap_d = cap_merged;
            end else if (!at_last) begin
                err_short_d = 1'b1;
            end else if (axis_tlast) begin
                vec_d       = cap_merged;
                vec_valid_d = 1'b1;
            end else begin
                err_long_d = 1'b1;
            end
        end
    end

    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;

`ifdef AXIS_TO_VECTOR_ERR_COUNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (sreset) begin
            err_cnt_q <= '0;
        end else if ((err_short_d || err_long_d) && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
